// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Double-buffered row-scan driver for a bicolour (red/green) LED dot matrix.
//   Host logic writes pixels into the back buffer. The scanner multiplexes the
//   front buffer onto the row/column pins and blanks the columns for the first
//   BLANK cycles of every row dwell. Front/back exchange happens only at a frame
//   boundary, so a displayed frame never tears.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     wr_en/wr_row/wr_col/wr_color
//                       write one back-buffer pixel (bit0 red, bit1 green)
//     clr               zero the whole back buffer (wins over wr_en)
//     swap_req          request a front/back exchange at the next frame boundary
//     swap_pending      request accepted, not yet executed
//     swap_done         one-cycle pulse when the exchange executes
//     frame_start       one-cycle pulse on the first output cycle of row 0
//     output_row        row select (polarity set by ROW_ACT_LOW)
//     output_col_r/g    red/green column drive, active-high
//
//   Optional build macro LED_MATRIX_BRIGHTNESS_EN adds input brightness[3:0];
//   columns are then driven only while a free-running 4-bit PWM counter is
//   <= brightness.
module led_matrix_scanner #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int SCAN_DIV    = 1000,
    parameter int BLANK       = 50,
    parameter int ROW_ACT_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [1:0]                wr_color,
    input  logic                      clr,
    input  logic                      swap_req,
`ifdef LED_MATRIX_BRIGHTNESS_EN
    input  logic [3:0]                brightness,
`endif
    output logic                      swap_pending,
    output logic                      swap_done,
    output logic                      frame_start,
    output logic [ROWS-1:0]           output_row,
    output logic [COLS-1:0]           output_col_r,
    output logic [COLS-1:0]           output_col_g
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SCAN_DIV);

    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW:0]     ROWS_L   = (RW+1)'(ROWS);
    localparam logic [CW:0]     COLS_L   = (CW+1)'(COLS);
    localparam logic [DW:0]     BLANK_L  = (DW+1)'(BLANK);
    localparam logic [ROWS-1:0] ROW_IDLE = (ROW_ACT_LOW != 0) ? '1 : '0;

    // Framebuffers: index [buffer][row], one bit per column.
    logic [COLS-1:0] buf_r_q [2][ROWS];
    logic [COLS-1:0] buf_g_q [2][ROWS];

    logic            front_q,        front_d;
    logic [DW-1:0]   div_cnt_q,      div_cnt_d;
    logic [RW-1:0]   row_idx_q,      row_idx_d;
    logic            swap_pending_q, swap_pending_d;
    logic            swap_done_q,    swap_done_d;
    logic            frame_start_q,  frame_start_d;
    logic [ROWS-1:0] row_q,          row_d;
    logic [COLS-1:0] col_r_q,        col_r_d;
    logic [COLS-1:0] col_g_q,        col_g_d;

    logic            back_idx;
    logic            wr_ok;
    logic            div_last;
    logic            frame_end;
    logic            do_swap;
    logic            col_on;
    logic [ROWS-1:0] row_sel;

`ifdef LED_MATRIX_BRIGHTNESS_EN
    logic [3:0]      pwm_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end
`endif

    assign back_idx = ~front_q;
    assign wr_ok    = ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);

    always_comb begin
        div_last  = (div_cnt_q == DIV_LAST);
        frame_end = div_last && (row_idx_q == ROW_LAST);

        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        row_idx_d = row_idx_q;
        if (div_last) row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + 1'b1;

        // A request arriving in the boundary cycle itself is honoured there.
        do_swap        = frame_end && (swap_pending_q || swap_req);
        front_d        = do_swap ? ~front_q : front_q;
        swap_pending_d = do_swap ? 1'b0 : (swap_pending_q || swap_req);
        swap_done_d    = do_swap;
        frame_start_d  = (row_idx_q == '0) && (div_cnt_q == '0);

        row_sel = '0;
        for (int unsigned r = 0; r < ROWS; r++) row_sel[r] = (row_idx_q == RW'(r));
        row_d = (ROW_ACT_LOW != 0) ? ~row_sel : row_sel;

        col_on = ({1'b0, div_cnt_q} >= BLANK_L);
`ifdef LED_MATRIX_BRIGHTNESS_EN
        col_on = col_on && (pwm_cnt_q <= brightness);
`endif
        col_r_d = col_on ? buf_r_q[front_q][row_idx_q] : '0;
        col_g_d = col_on ? buf_g_q[front_q][row_idx_q] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r_q <= '{default: '0};
            buf_g_q <= '{default: '0};
        end else if (clr) begin
            buf_r_q[back_idx] <= '{default: '0};
            buf_g_q[back_idx] <= '{default: '0};
        end else if (wr_en && wr_ok) begin
            buf_r_q[back_idx][wr_row][wr_col] <= wr_color[0];
            buf_g_q[back_idx][wr_row][wr_col] <= wr_color[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q        <= 1'b0;
            div_cnt_q      <= '0;
            row_idx_q      <= '0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            frame_start_q  <= 1'b0;
            row_q          <= ROW_IDLE;
            col_r_q        <= '0;
            col_g_q        <= '0;
        end else begin
            front_q        <= front_d;
            div_cnt_q      <= div_cnt_d;
            row_idx_q      <= row_idx_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            frame_start_q  <= frame_start_d;
            row_q          <= row_d;
            col_r_q        <= col_r_d;
            col_g_q        <= col_g_d;
        end
    end

    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;
    assign frame_start  = frame_start_q;
    assign output_row   = row_q;
    assign output_col_r = col_r_q;
    assign output_col_g = col_g_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner
//   Scoreboard bench for led_matrix_scanner. Two instances share clock and
//   reset: dut1 (8x8, SCAN_DIV=4, BLANK=1) and dut2 (10 rows) for the
//   row-range cases. Expected output records, tagged with the cycle number k
//   (posedges since reset release), are queued up front; a monitor on the
//   falling edge pops and compares each record when its cycle arrives.
module tb_led_matrix_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic       wr_en1, clr1, swap_req1;
    logic [2:0] wr_row1, wr_col1;
    logic [1:0] wr_color1;
    logic       sp1, sd1, fs1;
    logic [7:0] row1, cr1, cg1;

    logic       wr_en2, clr2, swap_req2;
    logic [3:0] wr_row2;
    logic [2:0] wr_col2;
    logic [1:0] wr_color2;
    logic       sp2, sd2, fs2;
    logic [9:0] row2;
    logic [7:0] cr2, cg2;

    led_matrix_scanner #(.ROWS(8), .COLS(8), .SCAN_DIV(4), .BLANK(1), .ROW_ACT_LOW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_row(wr_row1), .wr_col(wr_col1),
        .wr_color(wr_color1), .clr(clr1), .swap_req(swap_req1),
`ifdef LED_MATRIX_BRIGHTNESS_EN
        .brightness(4'hF),
`endif
        .swap_pending(sp1), .swap_done(sd1), .frame_start(fs1),
        .output_row(row1), .output_col_r(cr1), .output_col_g(cg1)
    );

    led_matrix_scanner #(.ROWS(10), .COLS(8), .SCAN_DIV(4), .BLANK(1), .ROW_ACT_LOW(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_row(wr_row2), .wr_col(wr_col2),
        .wr_color(wr_color2), .clr(clr2), .swap_req(swap_req2),
`ifdef LED_MATRIX_BRIGHTNESS_EN
        .brightness(4'hF),
`endif
        .swap_pending(sp2), .swap_done(sd2), .frame_start(fs2),
        .output_row(row2), .output_col_r(cr2), .output_col_g(cg2)
    );

    typedef struct {
        int          k;
        logic [15:0] row;
        logic [7:0]  cr;
        logic [7:0]  cg;
        logic        fs;
        logic        sd;
        logic        sp;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   k = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // dut1 expectations. Front buffer per frame f (32 cycles):
    // f0,f1 empty; f2 red (2,5); f3 empty; f4 cleared; f5,f6 green (7,0).
    // post=1: first frame after the mid-scan reset, everything dark.
    function automatic exp_t exp1(int kk, bit post);
        exp_t       e;
        int         p, r, d, f;
        logic [7:0] rv;
        p = kk - 1; r = (p / 4) % 8; d = p % 4; f = p / 32;
        rv = 8'h01 << r;
        e.k   = kk;
        e.row = {8'h00, ~rv};
        e.fs  = (p % 32 == 0);
        e.cr  = 8'h00;
        e.cg  = 8'h00;
        e.sd  = 1'b0;
        e.sp  = 1'b0;
        if (!post) begin
            e.sd = (kk == 64) || (kk == 96) || (kk == 128) || (kk == 160);
            e.sp = (kk >= 41 && kk <= 63) || (kk >= 71 && kk <= 95) ||
                   (kk >= 102 && kk <= 127) || (kk >= 201 && kk <= 205);
            if (d != 0) begin
                if (f == 2 && r == 2) e.cr = 8'h20;
                if (f >= 5 && r == 7) e.cg = 8'h01;
            end
        end
        return e;
    endfunction

    // dut2: row 9 pixel yellow at column 3 after the swap at k=40; row 10 write dropped.
    function automatic exp_t exp2(int kk);
        exp_t       e;
        int         p, r, d;
        logic [9:0] rv;
        p = kk - 1; r = (p / 4) % 10; d = p % 4;
        rv = 10'h001 << r;
        e.k   = kk;
        e.row = {6'h00, ~rv};
        e.fs  = (p % 40 == 0);
        e.sd  = (kk == 40);
        e.sp  = (kk >= 5 && kk <= 39);
        e.cr  = (kk >= 41 && r == 9 && d != 0) ? 8'h08 : 8'h00;
        e.cg  = e.cr;
        return e;
    endfunction

    function automatic exp_t exp_rst(logic [15:0] idle);
        exp_t e;
        e.k = 0; e.row = idle; e.cr = '0; e.cg = '0; e.fs = 0; e.sd = 0; e.sp = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].k <= k) begin
            e1 = q1.pop_front();
            n_checks++;
            if (e1.k != k || {8'h00, row1} !== e1.row || cr1 !== e1.cr || cg1 !== e1.cg ||
                fs1 !== e1.fs || sd1 !== e1.sd || sp1 !== e1.sp) begin
                n_fail++;
                $display("FAIL dut1 k=%0d (exp k=%0d) got/exp row=%h/%h r=%h/%h g=%h/%h fs=%b/%b sd=%b/%b sp=%b/%b",
                         k, e1.k, row1, e1.row[7:0], cr1, e1.cr, cg1, e1.cg, fs1, e1.fs, sd1, e1.sd, sp1, e1.sp);
            end
        end
        if (q2.size() > 0 && q2[0].k <= k) begin
            e2 = q2.pop_front();
            n_checks++;
            if (e2.k != k || {6'h00, row2} !== e2.row || cr2 !== e2.cr || cg2 !== e2.cg ||
                fs2 !== e2.fs || sd2 !== e2.sd || sp2 !== e2.sp) begin
                n_fail++;
                $display("FAIL dut2 k=%0d (exp k=%0d) got/exp row=%h/%h r=%h/%h g=%h/%h fs=%b/%b sd=%b/%b sp=%b/%b",
                         k, e2.k, row2, e2.row[9:0], cr2, e2.cr, cg2, e2.cg, fs2, e2.fs, sd2, e2.sd, sp2, e2.sp);
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: run did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        wr_en1 = 0; clr1 = 0; swap_req1 = 0; wr_row1 = '0; wr_col1 = '0; wr_color1 = '0;
        wr_en2 = 0; clr2 = 0; swap_req2 = 0; wr_row2 = '0; wr_col2 = '0; wr_color2 = '0;

        q1.push_back(exp_rst(16'h00FF));
        q2.push_back(exp_rst(16'h03FF));
        for (int kk = 1; kk <= 205; kk++) q1.push_back(exp1(kk, 1'b0));
        for (int kk = 5; kk <= 80; kk++)  q2.push_back(exp2(kk));

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Inputs driven on the falling edge with count k are sampled at posedge k+1.
        while (k < 205) begin
            @(negedge clk);
            wr_en1 = 0; clr1 = 0; swap_req1 = 0;
            wr_en2 = 0; swap_req2 = 0;
            case (k)
                2:   begin wr_en2 = 1; wr_row2 = 4'd9;  wr_col2 = 3'd3; wr_color2 = 2'b11; end
                3:   begin wr_en2 = 1; wr_row2 = 4'd10; wr_col2 = 3'd1; wr_color2 = 2'b01; end
                4:   swap_req2 = 1;
                40:  begin wr_en1 = 1; wr_row1 = 3'd2; wr_col1 = 3'd5; wr_color1 = 2'b01; swap_req1 = 1; end
                70, 75, 80: swap_req1 = 1;
                100: begin clr1 = 1; wr_en1 = 1; wr_row1 = 3'd0; wr_col1 = 3'd0; wr_color1 = 2'b11; end
                101: swap_req1 = 1;
                159: begin swap_req1 = 1; wr_en1 = 1; wr_row1 = 3'd7; wr_col1 = 3'd0; wr_color1 = 2'b10; end
                200: swap_req1 = 1;
                default: ;
            endcase
        end

        // Mid-frame reset with a swap pending: scan restarts, pending is discarded,
        // both buffers come back empty.
        #2 rst_n = 1'b0;
        q1.push_back(exp_rst(16'h00FF));
        q2.push_back(exp_rst(16'h03FF));
        for (int kk = 1; kk <= 32; kk++) q1.push_back(exp1(kk, 1'b1));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);

        n_checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d records left, required 0/0", q1.size(), q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
